// File: rtl/hcu_kt_scheduler.sv
// hcu_kt_scheduler: streams SHA-2 round constants K[t] from the shared constant
// ROM to the madd_Kt adder through a 2-entry output buffer with valid/ready.
module hcu_kt_scheduler #(
  parameter int KW   = 64,
  parameter int AW   = 7,
  parameter int SKID = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          mode64_i,
  input  logic          abort,
  output logic          idle,
  output logic          rom_en,
  output logic [AW-1:0] rom_addr,
  input  logic [KW-1:0] rom_data,
  output logic [KW-1:0] kt_o,
  output logic          kt_valid,
  input  logic          kt_ready,
  output logic [AW-1:0] round_o,
  output logic          kt_last,
  output logic          mode64_o,
  output logic          done
);

  typedef enum logic {
    ST_IDLE,
    ST_RUN
  } state_e;

  state_e        state_q, state_d;
  logic          mode64_q, mode64_d;
  logic [AW-1:0] next_addr_q, next_addr_d;
  logic          done_q, done_d;
  logic [1:0]    occ_q, occ_d;
  logic          inflight_q;
  logic [AW-1:0] inflight_addr_q;
  logic          wr_ptr_q, rd_ptr_q;

  logic [KW-1:0] buf_data_q  [SKID];
  logic [AW-1:0] buf_round_q [SKID];

  logic [AW-1:0] last_round;
  logic [AW-1:0] head_round;
  logic          pop;
  logic          push;
  logic [2:0]    level;

  assign last_round = mode64_q ? AW'(79) : AW'(63);
  assign head_round = buf_round_q[rd_ptr_q];

  // Outputs read as zero while the buffer is empty, so reset and flush look alike.
  assign kt_valid = (occ_q != 2'd0);
  assign kt_o     = kt_valid ? buf_data_q[rd_ptr_q] : '0;
  assign round_o  = kt_valid ? head_round : '0;
  assign kt_last  = kt_valid && (head_round == last_round);
  assign idle     = (state_q == ST_IDLE);
  assign mode64_o = mode64_q;
  assign done     = done_q;

  assign pop  = kt_valid && kt_ready;
  assign push = inflight_q && !abort;

  // A read may only issue if its data is guaranteed a buffer slot on arrival.
  assign level    = {1'b0, occ_q} + {2'b00, inflight_q};
  assign rom_en   = (state_q == ST_RUN) && !abort && (next_addr_q <= last_round) &&
                    (level < (3'(SKID) + {2'b00, pop}));
  assign rom_addr = rom_en ? next_addr_q : '0;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; that is what keeps synthesis from inferring a latch.
  always_comb begin
    state_d     = state_q;
    mode64_d    = mode64_q;
    next_addr_d = next_addr_q;
    done_d      = 1'b0;
    occ_d       = occ_q + {1'b0, push} - {1'b0, pop};
    if (abort) begin
      state_d = ST_IDLE;
      occ_d   = 2'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_d     = ST_RUN;
            mode64_d    = mode64_i;
            next_addr_d = '0;
          end
        end
        ST_RUN: begin
          if (rom_en) next_addr_d = next_addr_q + AW'(1);
          if (pop && kt_last) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= ST_IDLE;
      mode64_q        <= 1'b0;
      next_addr_q     <= '0;
      done_q          <= 1'b0;
      occ_q           <= 2'd0;
      inflight_q      <= 1'b0;
      inflight_addr_q <= '0;
      wr_ptr_q        <= 1'b0;
      rd_ptr_q        <= 1'b0;
    end else begin
      state_q         <= state_d;
      mode64_q        <= mode64_d;
      next_addr_q     <= next_addr_d;
      done_q          <= done_d;
      occ_q           <= occ_d;
      inflight_q      <= rom_en;
      inflight_addr_q <= next_addr_q;
      if (abort) begin
        wr_ptr_q <= 1'b0;
        rd_ptr_q <= 1'b0;
      end else begin
        wr_ptr_q <= wr_ptr_q ^ push;
        rd_ptr_q <= rd_ptr_q ^ pop;
      end
    end
  end

  // NOTE: buffer storage is deliberately not reset; occupancy alone decides
  // whether an entry is meaningful, so the data array stays plain flops/RAM.
  always_ff @(posedge clk) begin
    if (push) begin
      buf_data_q[wr_ptr_q]  <= rom_data;
      buf_round_q[wr_ptr_q] <= inflight_addr_q;
    end
  end

endmodule
